// File: rtl/gpu_clk_sequencer_pkg.sv
// rtl/gpu_clk_sequencer_pkg.sv - state type and sizing helpers for the GPU clock sequencer
package gpu_clk_sequencer_pkg;

`include "gpu_clk_defs.vh"

  typedef enum logic [2:0] {
    ST_PLL_RST   = `GPU_CLK_ST_PLL_RST,
    ST_WAIT_LOCK = `GPU_CLK_ST_WAIT_LOCK,
    ST_STABLE    = `GPU_CLK_ST_STABLE,
    ST_RUN       = `GPU_CLK_ST_RUN,
    ST_FAULT     = `GPU_CLK_ST_FAULT
  } seq_state_e;

  localparam int LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpu_clk_defs.vh
// rtl/gpu_clk_defs.vh - 3-bit sequencer state encodings shared with the debug/status register block
`ifndef GPU_CLK_DEFS_VH
`define GPU_CLK_DEFS_VH

`define GPU_CLK_ST_PLL_RST   3'd0
`define GPU_CLK_ST_WAIT_LOCK 3'd1
`define GPU_CLK_ST_STABLE    3'd2
`define GPU_CLK_ST_RUN       3'd3
`define GPU_CLK_ST_FAULT     3'd4

`endif

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous status inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpu_clk_sequencer.sv
// rtl/gpu_clk_sequencer.sv - PLL reset/lock sequencer gating the pixel/TMDS domain reset
module gpu_clk_sequencer
  import gpu_clk_sequencer_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 25000,
  parameter int LOCK_STABLE_CYCLES  = 4096,
  parameter int MAX_RETRIES         = 3
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        fault_clear,
  output logic        pll_rst,
  output logic        video_rst,
  output logic        ready,
  output logic        fault,
  output logic [7:0]  loss_count,
  output logic [2:0]  state_dbg
);

  localparam int TMR_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int RW      = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0]     TMR_ONE      = TW'(1);
  localparam logic [TW-1:0]     RST_LAST     = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]     STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]     RETRY_ONE    = RW'(1);
  localparam logic [RW-1:0]     RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0] LOSS_SAT     = '1;
  localparam logic [LOSS_W-1:0] LOSS_ONE     = LOSS_W'(1);

  seq_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lock_s;

  logic pll_rst_q, pll_rst_d;
  logic video_rst_q, video_rst_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  // pll_locked comes from the PLL's own domain; only lock_s may steer the FSM
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i (clk_25mhz),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      video_rst_q <= video_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_PLL_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_ONE;
            state_d = ST_PLL_RST;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_STABLE: begin
        // a drop on the final counted cycle still wins over promotion to RUN
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          if (loss_q != LOSS_SAT) begin
            loss_d = loss_q + LOSS_ONE;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d = ST_PLL_RST;
          timer_d = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        timer_d = '0;
      end
    endcase
  end

  // decoding from the next state keeps the outputs glitch-free without a cycle of lag
  always_comb begin
    pll_rst_d   = (state_d == ST_PLL_RST);
    video_rst_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  assign pll_rst    = pll_rst_q;
  assign video_rst  = video_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign loss_count = loss_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_gpu_clk_sequencer.sv
// tb/tb_gpu_clk_sequencer.sv - table-driven, scoreboarded bench for the GPU clock sequencer
module tb_gpu_clk_sequencer;
  import gpu_clk_sequencer_pkg::*;

  logic       clk_25mhz = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       fault_clear = 1'b0;
  logic       pll_rst;
  logic       video_rst;
  logic       ready;
  logic       fault;
  logic [7:0] loss_count;
  logic [2:0] state_dbg;

  always #5 clk_25mhz = ~clk_25mhz;

  gpu_clk_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .fault_clear (fault_clear),
    .pll_rst     (pll_rst),
    .video_rst   (video_rst),
    .ready       (ready),
    .fault       (fault),
    .loss_count  (loss_count),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    string      nm;
    bit         r;
    bit         l;
    bit         f;
    int         cyc;
    seq_state_e st;
    int         loss;
    int         pend;
  } vec_t;

  typedef struct {
    string      nm;
    seq_state_e st;
    int         loss;
    int         pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pulse_ends = 0;
  bit   prst_prev = 1'b1;

  // counts completed pll_rst pulses since the last reset
  always @(posedge clk_25mhz) begin
    #1;
    if (rst) begin
      pulse_ends = 0;
      prst_prev  = 1'b1;
    end else begin
      if (prst_prev && !pll_rst) pulse_ends++;
      prst_prev = pll_rst;
    end
  end

  function automatic vec_t mk(input string nm, input bit r, input bit l, input bit f,
                              input int cyc, input seq_state_e st, input int loss, input int pend);
    vec_t v;
    v.nm = nm; v.r = r; v.l = l; v.f = f; v.cyc = cyc;
    v.st = st; v.loss = loss; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input seq_state_e st, input int loss, input int pend);
    exp_t e;
    e.nm = nm; e.st = st; e.loss = loss; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".state"},     int'(state_dbg),  int'(e.st));
      chk({e.nm, ".pll_rst"},   int'(pll_rst),    int'(e.st == ST_PLL_RST));
      chk({e.nm, ".video_rst"}, int'(video_rst),  int'(e.st != ST_RUN));
      chk({e.nm, ".ready"},     int'(ready),      int'(e.st == ST_RUN));
      chk({e.nm, ".fault"},     int'(fault),      int'(e.st == ST_FAULT));
      chk({e.nm, ".loss"},      int'(loss_count), e.loss);
      if (e.pend >= 0) chk({e.nm, ".pulses"}, pulse_ends, e.pend);
    end
  endtask

  task automatic run_vec(input vec_t v);
    rst = v.r;
    pll_locked = v.l;
    fault_clear = v.f;
    push_exp(v.nm, v.st, v.loss, v.pend);
    repeat (v.cyc) @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    check_out();
  endtask

  task automatic wait_sig(input string nm, input int which, input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk_25mhz);
      case (which)
        0:       hit = video_rst;
        1:       hit = ready;
        default: hit = (state_dbg == ST_STABLE);
      endcase
    end
    chk(nm, int'(hit), 1);
  endtask

  initial begin
    // clean start: lock raised 10 cycles after release, RUN on the 11th edge counting its sample
    tbl.push_back(mk("reset",       1, 0, 0,  2, ST_PLL_RST,   0,  0));
    tbl.push_back(mk("rst_pulse",   0, 0, 0,  3, ST_PLL_RST,   0, -1));
    tbl.push_back(mk("rst_end",     0, 0, 0,  1, ST_WAIT_LOCK, 0,  1));
    tbl.push_back(mk("wait_nolock", 0, 0, 0,  6, ST_WAIT_LOCK, 0, -1));
    tbl.push_back(mk("lock_pre",    0, 1, 0, 10, ST_STABLE,    0, -1));
    tbl.push_back(mk("lock_ready",  0, 1, 0,  1, ST_RUN,       0,  1));
    // lock loss in RUN
    tbl.push_back(mk("loss_pre",    0, 0, 0,  2, ST_RUN,       0, -1));
    tbl.push_back(mk("loss_vrst",   0, 0, 0,  1, ST_PLL_RST,   1, -1));
    tbl.push_back(mk("loss_pulse",  0, 1, 0,  3, ST_PLL_RST,   1, -1));
    tbl.push_back(mk("loss_pend",   0, 1, 0,  1, ST_WAIT_LOCK, 1,  2));
    tbl.push_back(mk("relock",      0, 1, 0,  1, ST_STABLE,    1, -1));
    tbl.push_back(mk("relock_pre",  0, 1, 0,  7, ST_STABLE,    1, -1));
    tbl.push_back(mk("relock_run",  0, 1, 0,  1, ST_RUN,       1,  2));
    // chatter: 5 high, 1 low, then high
    tbl.push_back(mk("reset2",      1, 0, 0,  1, ST_PLL_RST,   0,  0));
    tbl.push_back(mk("ch_wait",     0, 0, 0,  4, ST_WAIT_LOCK, 0,  1));
    tbl.push_back(mk("ch_high",     0, 1, 0,  5, ST_STABLE,    0, -1));
    tbl.push_back(mk("ch_low",      0, 0, 0,  1, ST_STABLE,    0, -1));
    tbl.push_back(mk("ch_drop",     0, 1, 0,  2, ST_WAIT_LOCK, 0, -1));
    tbl.push_back(mk("ch_rest",     0, 1, 0,  1, ST_STABLE,    0, -1));
    tbl.push_back(mk("ch_pre",      0, 1, 0,  7, ST_STABLE,    0, -1));
    tbl.push_back(mk("ch_run",      0, 1, 0,  1, ST_RUN,       0,  1));
    // never lock: three pulses then FAULT, then fault_clear
    tbl.push_back(mk("reset3",      1, 0, 0,  1, ST_PLL_RST,   0,  0));
    tbl.push_back(mk("nl_wait0",    0, 0, 0,  4, ST_WAIT_LOCK, 0,  1));
    tbl.push_back(mk("nl_t31a",     0, 0, 0, 31, ST_WAIT_LOCK, 0, -1));
    tbl.push_back(mk("nl_retry1",   0, 0, 0,  1, ST_PLL_RST,   0, -1));
    tbl.push_back(mk("nl_wait1",    0, 0, 0,  4, ST_WAIT_LOCK, 0,  2));
    tbl.push_back(mk("nl_retry2",   0, 0, 0, 32, ST_PLL_RST,   0, -1));
    tbl.push_back(mk("nl_wait2",    0, 0, 0,  4, ST_WAIT_LOCK, 0,  3));
    tbl.push_back(mk("nl_t31c",     0, 0, 0, 31, ST_WAIT_LOCK, 0, -1));
    tbl.push_back(mk("nl_fault",    0, 0, 0,  1, ST_FAULT,     0,  3));
    tbl.push_back(mk("fault_hold",  0, 0, 0,  5, ST_FAULT,     0,  3));
    tbl.push_back(mk("fclr",        0, 0, 1,  1, ST_PLL_RST,   0,  3));
    tbl.push_back(mk("fclr_pulse",  0, 0, 0,  3, ST_PLL_RST,   0,  3));
    tbl.push_back(mk("fclr_wait",   0, 0, 0,  1, ST_WAIT_LOCK, 0,  4));
    tbl.push_back(mk("fclr_ignore", 0, 0, 1,  3, ST_WAIT_LOCK, 0,  4));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    fault_clear = 1'b0;

    // 260 lock losses: loss_count must stop at 255
    pll_locked = 1'b1;
    wait_sig("sat_first_run", 1, 40);
    for (int i = 1; i <= 260; i++) begin
      pll_locked = 1'b0;
      wait_sig("sat_drop", 0, 10);
      pll_locked = 1'b1;
      wait_sig("sat_run", 1, 40);
      push_exp("sat_loss", ST_RUN, (i > 255) ? 255 : i, -1);
      check_out();
    end

    // asynchronous reset while in STABLE, then a full restart
    pll_locked = 1'b0;
    wait_sig("rs_drop", 0, 10);
    pll_locked = 1'b1;
    wait_sig("rs_stable", 2, 40);
    @(negedge clk_25mhz);
    #3 rst = 1'b1;
    #1;
    push_exp("rst_async", ST_PLL_RST, 0, -1);
    check_out();
    @(negedge clk_25mhz);
    run_vec(mk("rs_pulse",   0, 1, 0, 3, ST_PLL_RST,   0, -1));
    run_vec(mk("rs_wait",    0, 1, 0, 1, ST_WAIT_LOCK, 0,  1));
    run_vec(mk("rs_stable0", 0, 1, 0, 1, ST_STABLE,    0, -1));
    run_vec(mk("rs_pre",     0, 1, 0, 7, ST_STABLE,    0, -1));
    run_vec(mk("rs_run",     0, 1, 0, 1, ST_RUN,       0,  1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_clk_sequencer.md
GPU_CLK_SEQUENCER -- requirements
Module: gpu_clk_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: PLL reset pulse width in clk_25mhz cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 25000 (1 ms): maximum wait for lock after one PLL reset.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 4096: number of consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: timeouts tolerated before fault.
REQ-005 SHALL have port clk_25mhz  in  1  board 25 MHz clock, which also feeds the PLL input, so this block runs while the PLL is unlocked.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pll_locked  in  1  raw PLL LOCK, asynchronous to clk_25mhz.
REQ-008 SHALL have port fault_clear  in  1  single-cycle pulse that restarts sequencing from FAULT.
REQ-009 SHALL have port pll_rst  out  1  drives the PLL RST input.
REQ-010 SHALL have port video_rst  out  1  reset for the pixel/TMDS domain; high whenever clocks are not trusted.
REQ-011 SHALL have port ready  out  1  high only in RUN.
REQ-012 SHALL have port fault  out  1  high only in FAULT.
REQ-013 SHALL have port loss_count  out  8  count of lock losses seen in RUN, saturating at 255.
REQ-014 SHALL have port state_dbg  out  3  current state encoding.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer to form lock_s; all decisions SHALL use lock_s only.
REQ-016 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT, sharing one timer wide enough for the largest cycle parameter.
REQ-017 SHALL hold pll_rst=1 in PLL_RST for exactly RST_PULSE_CYCLES cycles, then enter WAIT_LOCK with the timer cleared.
REQ-018 WAIT_LOCK: on lock_s=1, SHALL go to STABLE with the timer cleared; when the timer reaches LOCK_TIMEOUT_CYCLES without lock, SHALL act per REQ-019.
REQ-019 On timeout: if retry_cnt<MAX_RETRIES, SHALL increment retry_cnt and go to PLL_RST; otherwise SHALL go to FAULT.
REQ-020 STABLE: after LOCK_STABLE_CYCLES consecutive cycles of lock_s=1, SHALL go to RUN and clear retry_cnt; any lock_s=0 SHALL return to WAIT_LOCK with the timer cleared and retry_cnt unchanged.
REQ-021 RUN: on lock_s=0, SHALL go to PLL_RST on the next edge and increment loss_count (saturating at 255).
REQ-022 FAULT: SHALL hold pll_rst=0 and video_rst=1; fault_clear=1 SHALL go to PLL_RST with retry_cnt=0; fault_clear SHALL be ignored in all other states.
REQ-023 All outputs SHALL be registered and decoded from the next state: video_rst=(next!=RUN), ready=(next==RUN), fault=(next==FAULT), pll_rst=(next==PLL_RST).
REQ-024 Latency from pll_locked first sampled high (stable) in WAIT_LOCK to video_rst low SHALL be 3+LOCK_STABLE_CYCLES cycles.
REQ-025 Latency from pll_locked sampled low in RUN to video_rst high SHALL be 3 cycles.
REQ-026 Lock loss and the stable-count completion in the same cycle SHALL resolve as lock loss.

Reset
REQ-027 While rst=1, the block SHALL hold: state=PLL_RST, timer=0, retry_cnt=0, loss_count=0, synchronizer flops=0, pll_rst=1, video_rst=1, ready=0, fault=0.
REQ-028 After rst deasserts, pll_rst SHALL remain high for a further RST_PULSE_CYCLES cycles.
REQ-029 rst asserted mid-operation, in any state, SHALL immediately force the REQ-027 values.

Structure
REQ-030 State encodings (3-bit) SHALL live in the shared header gpu_clk_defs.vh for reuse by the debug/status register block.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_2ff, reusable for other asynchronous status inputs.

Verification
Bench parameters: RST_PULSE=4, TIMEOUT=32, STABLE=8, RETRIES=2.
REQ-032 Clean start: release rst, raise pll_locked 10 cycles later -> pll_rst high for 4 cycles after release; video_rst low and ready=1 exactly 11 cycles after pll_locked first sampled high.
REQ-033 Chatter: pll_locked high 5 cycles, low 1 cycle, then high -> ready stays 0 until 8 consecutive synced-high cycles; no pll_rst pulse.
REQ-034 Lock loss in RUN: drop pll_locked -> video_rst high 3 cycles later; pll_rst 4-cycle pulse; loss_count 0->1; with lock restored, returns to RUN.
REQ-035 Never lock -> three pll_rst pulses (initial plus 2 retries), each separated by 32 WAIT_LOCK cycles; then fault=1, pll_rst=0; fault_clear pulse -> new pll_rst pulse.
REQ-036 Force 260 lock losses -> loss_count saturates at 255.
REQ-037 Assert rst during STABLE -> REQ-027 values on the same cycle; the full sequence restarts.
